// File: rtl/mac_result_collector_pkg.sv
// mac_result_collector_pkg: result width and collector FSM encodings.
package mac_result_collector_pkg;
  localparam int DWIDTH = 32;
  typedef enum logic [1:0] {COLL_IDLE, COLL_ACTIVE, COLL_DONE} coll_state_e;
endpackage

// File: rtl/mac_result_collector_result_fifo.sv
// result_fifo: width/depth synchronous FIFO with flush; a push while full only lands with a same-cycle pop.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign level = cnt_q;
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  // Head reads as zero when empty so the port shows reset values without resetting storage.
  assign rdata = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: buffers adder results tagged with row/tile position and drains them over valid/ready.
// Define COLLECTOR_OVF_EN to enable the sticky overflow flag; otherwise overflow is tied low.
module mac_result_collector
  import mac_result_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int COLS  = 4,
  parameter int ROWS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DWIDTH-1:0]      sum_in,
  input  logic                   valid_in,
  input  logic                   can_use_in,
  input  logic                   flush,
  output logic [DWIDTH-1:0]      wb_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic                   wb_last,
  output logic                   tile_done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  coll_state_e       state_q, state_d;
  logic              push, pop, accept, full, empty, row_last, tile_last;
  logic [DWIDTH+1:0] head;
  logic [LW-1:0]     level_nxt;
  assign push      = valid_in & can_use_in;
  assign pop       = wb_valid & wb_ready;
  assign accept    = push & (~full | pop);
  assign row_last  = col_q == CW'(COLS - 1);
  assign tile_last = row_last & (row_q == RW'(ROWS - 1));
  assign level_nxt = level + LW'(accept) - LW'(pop);
  result_fifo #(.W(DWIDTH + 2), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({tile_last, row_last, sum_in}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  assign wb_valid  = ~empty;
  assign wb_data   = head[DWIDTH-1:0];
  assign wb_last   = head[DWIDTH];
  assign tile_done = state_q == COLL_DONE;
  always_comb begin
    col_d   = accept ? (row_last ? '0 : col_q + CW'(1)) : col_q;
    row_d   = (accept & row_last) ? (tile_last ? '0 : row_q + RW'(1)) : row_q;
    state_d = state_q == COLL_IDLE   ? (accept ? COLL_ACTIVE : COLL_IDLE) :
              state_q == COLL_ACTIVE ? ((pop & head[DWIDTH+1]) ? COLL_DONE : COLL_ACTIVE) :
              (level_nxt != '0 ? COLL_ACTIVE : COLL_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= COLL_IDLE;
    end else if (flush) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= COLL_IDLE;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
    end
  end
`ifdef COLLECTOR_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (flush) ovf_q <= 1'b0;
    else if (push & full & ~pop) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_mac_result_collector.sv
// tb_mac_result_collector: table-driven tile check, hand corner sequences and random traffic against a queue model.
module tb_mac_result_collector;
  import mac_result_collector_pkg::*;
  localparam int DEPTH = 8, COLS = 4, ROWS = 4, LW = $clog2(DEPTH) + 1;
`ifdef COLLECTOR_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic              clk = 1'b0, rst_n = 1'b0;
  logic [DWIDTH-1:0] sum_in = '0, wb_data;
  logic              valid_in = 1'b0, can_use_in = 1'b0, flush = 1'b0, wb_ready = 1'b0;
  logic              wb_valid, wb_last, tile_done, overflow;
  logic [LW-1:0]     level;
  mac_result_collector #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .valid_in(valid_in), .can_use_in(can_use_in),
    .flush(flush), .wb_data(wb_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_last(wb_last), .tile_done(tile_done), .overflow(overflow), .level(level)
  );
  always #5 clk = ~clk;
  typedef struct {logic tl; logic rl; logic [DWIDTH-1:0] d;} ent_t;
  typedef struct {
    logic v; logic [DWIDTH-1:0] d;
    logic ev; logic [DWIDTH-1:0] ed; logic el; logic etd; logic [LW-1:0] elv;
  } vec_t;
  ent_t q[$];
  int   acc_n = 0, vecs = 0, errs = 0;
  bit   ovf_m = 0, done_m = 0;
  vec_t tbl[19];
  task automatic check(input string nm, input logic v, input logic [DWIDTH-1:0] d, input logic l,
                       input logic td, input logic o, input logic [LW-1:0] lv);
    vecs++;
    if ({wb_valid, wb_data, wb_last, tile_done, overflow, level} !== {v, d, l, td, o, lv}) begin
      errs++;
      $display("FAIL %s @%0t: got v=%b d=%h last=%b done=%b ovf=%b lvl=%0d, want v=%b d=%h last=%b done=%b ovf=%b lvl=%0d",
               nm, $time, wb_valid, wb_data, wb_last, tile_done, overflow, level, v, d, l, td, o, lv);
    end
  endtask
  task automatic check_model(input string nm);
    logic ev;
    ev = q.size() > 0;
    check(nm, ev, ev ? q[0].d : '0, ev && q[0].rl, done_m, ovf_m, LW'(q.size()));
  endtask
  // Called at a negedge: checks current outputs, drives one beat, advances the model, waits for the edge.
  task automatic drive(input logic v, input logic cu, input logic [DWIDTH-1:0] d, input logic rdy,
                       input logic fl, input string nm);
    bit   pop, tl;
    ent_t e;
    check_model(nm);
    valid_in = v; can_use_in = cu; sum_in = d; wb_ready = rdy; flush = fl;
    if (fl) begin
      q.delete(); acc_n = 0; ovf_m = 0; done_m = 0;
    end else begin
      pop = q.size() > 0 && rdy;
      tl  = pop && q[0].tl;
      if (v && cu) begin
        if (q.size() < DEPTH || pop) begin
          e.tl = (acc_n % (COLS * ROWS)) == COLS * ROWS - 1;
          e.rl = (acc_n % COLS) == COLS - 1;
          e.d  = d;
          q.push_back(e);
          acc_n++;
        end else if (OVF) ovf_m = 1;
      end
      if (pop) void'(q.pop_front());
      done_m = tl && !done_m;
    end
    @(posedge clk);
  endtask
  task automatic step(input logic v, input logic cu, input logic [DWIDTH-1:0] d, input logic rdy,
                      input logic fl, input string nm);
    @(negedge clk);
    drive(v, cu, d, rdy, fl, nm);
  endtask
  task automatic idle(input int n, input logic rdy, input string nm);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy, 1'b0, nm);
  endtask
  initial begin
    for (int i = 0; i < 19; i++) begin
      tbl[i].v   = i < 16;
      tbl[i].d   = DWIDTH'(i + 1);
      tbl[i].ev  = i >= 1 && i <= 16;
      tbl[i].ed  = (i >= 1 && i <= 16) ? DWIDTH'(i) : '0;
      tbl[i].el  = i >= 1 && i <= 16 && i % 4 == 0;
      tbl[i].etd = i == 17;
      tbl[i].elv = (i >= 1 && i <= 16) ? LW'(1) : '0;
    end
    #12 check("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) @(negedge clk);
      check("tile_tbl", tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].etd, 1'b0, tbl[i].elv);
      drive(tbl[i].v, 1'b1, tbl[i].d, 1'b1, 1'b0, "tile");
    end
    for (int i = 0; i < 7; i++) step(1'b1, i % 2 == 0, DWIDTH'(32'h10 + i), 1'b1, 1'b0, "discard");
    idle(2, 1'b1, "discard_drain");
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, DWIDTH'(i), 1'b0, 1'b0, "ovf_fill");
    @(negedge clk);
    check("ovf_full", 1'b1, DWIDTH'(1), 1'b0, 1'b0, OVF, LW'(8));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, "ovf_drain");
    idle(9, 1'b1, "ovf_drain");
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, "ovf_flush");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DWIDTH'(32'h100 + i), 1'b0, 1'b0, "full_fill");
    step(1'b1, 1'b1, DWIDTH'(32'h200), 1'b1, 1'b0, "full_pushpop");
    @(negedge clk);
    check("full_pushpop_lvl", 1'b1, DWIDTH'(32'h101), 1'b0, 1'b0, 1'b0, LW'(8));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, "full_drain");
    idle(9, 1'b1, "full_drain");
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, $urandom, i % 2 == 0, 1'b0, "backpressure");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, i % 2 == 1, 1'b0, "bp_drain");
    idle(4, 1'b1, "bp_drain");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DWIDTH'(32'h50 + i), 1'b0, 1'b0, "flush_fill");
    step(1'b1, 1'b1, DWIDTH'(32'h77), 1'b1, 1'b1, "flush");
    @(negedge clk);
    check("after_flush", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, DWIDTH'(32'hAA), 1'b0, 1'b0, "flush_aa");
    @(negedge clk);
    check("flush_aa_head", 1'b1, DWIDTH'(32'hAA), 1'b0, 1'b0, 1'b0, LW'(1));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, "flush_aa_pop");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, DWIDTH'(32'h60 + i), 1'b0, 1'b0, "rst_fill");
    #3 rst_n = 1'b0;
    #1 check("mid_reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    q.delete(); acc_n = 0; ovf_m = 0; done_m = 0;
    valid_in = 1'b0; can_use_in = 1'b0; wb_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, DWIDTH'(32'hAA), 1'b0, 1'b0, "rst_aa");
    @(negedge clk);
    check("rst_aa_head", 1'b1, DWIDTH'(32'hAA), 1'b0, 1'b0, 1'b0, LW'(1));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, "rst_aa_pop");
    for (int i = 0; i < 400; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom, $urandom_range(1, 0) == 1,
           $urandom_range(59, 0) == 0, "random");
    idle(10, 1'b1, "final_drain");
    @(negedge clk);
    check_model("final");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
